crc32_frame_check: RTL and testbench
====================================

// Module: crc32_frame_check
// PURPOSE
// Parametrised streaming CRC-32 frame checker for the Ethernet receive path.
// Consumes a wire-order beat stream (DW bits per beat, e.g. RMII dibits or bytes) framed by axiiv.
// At frame end it reports pass/fail against the Ethernet residue, plus runt and alignment checks.
// Sits after the preamble/SFD stripper and before the firewall/aggregator; generalises the dibit-only checksum block.
// PARAMETERS
// DW         2             data bits per beat; legal values 1, 2, 4, 8
// POLY       32'h04C11DB7  CRC generator polynomial, normal (MSB-first) form
// INIT       32'hFFFFFFFF  CRC register seed at frame start
// RESIDUE    32'hC704DD7B  register value expected after data+FCS have been folded in
// MIN_BYTES  64            minimum frame length in bytes, including FCS; shorter frames are killed
// CNT_W      16            width of the byte counter
// PORTS
// clk          in   1      system clock, all logic on rising edge
// rst          in   1      asynchronous, active-low reset
// axiiv        in   1      beat valid; a frame is a contiguous run of axiiv=1 cycles
// axiid        in   DW     beat data; axiid[0] is the earliest bit on the wire
// done         out  1      one-cycle pulse: frame result valid
// kill         out  1      qualified by done: 1 = drop frame (bad CRC, runt or misaligned)
// crc_q        out  32     CRC register at frame end, held until next frame completes
// byte_count   out  CNT_W  whole bytes in the frame, held with crc_q, saturates at all-ones
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; done=0, kill=0, crc_q=0, byte_count=0; internal CRC=INIT, bit count=0.
// - CRC update per bit b, fed in order axiid[0]..axiid[DW-1]:
//   fb=crc[31]^b; crc={crc[30:0],1'b0}^(fb?POLY:0). All DW bits are folded in one cycle (unrolled); no final XOR.
// - Bit counter counts DW per beat. byte_count = bits>>3, saturating; no wrap-around.
// - FSM states:
//   IDLE:   axiiv=1 -> RUN; fold the beat into INIT (not the stale register); bits=DW.
//   RUN:    axiiv=1 -> fold the beat, stay in RUN.
//           axiiv=0 -> REPORT; latch crc_q, byte_count and verdict.
//   REPORT: done=1 for exactly this cycle. axiiv=1 -> RUN, beat folded into INIT (back-to-back frame). axiiv=0 -> IDLE.
// - Latency: done is high during the cycle after the first sample of axiiv=0; one cycle after the last beat.
// - Verdict: kill = (crc!=RESIDUE) | (bytes<MIN_BYTES) | (bits%8!=0); the compare uses the CRC after the last beat.
// - kill is 0 whenever done=0. crc_q and byte_count change only on entry to REPORT.
// - Single-beat frame: RUN lasts one cycle, then REPORT; kill=1 (runt/misaligned).
// - Reset mid-frame: the frame is discarded; no done pulse follows reset release.
// - axiid is ignored while axiiv=0; X on axiid while idle must not propagate to the outputs.
// TESTING
// 1. DW=2, MIN_BYTES=4: ASCII "123456789" + FCS bytes 26 39 F4 CB, each byte LSB first (52 beats)
//    -> one done pulse 1 cycle after the last beat; kill=0, crc_q=C704DD7B, byte_count=13.
// 2. Same frame with one data bit flipped -> done=1, kill=1, crc_q!=C704DD7B, byte_count=13.
// 3. Frames 1 and 2 back-to-back, one idle cycle between them (axiiv=1 during REPORT)
//    -> two done pulses; first kill=0, second kill=1; second CRC seeded from INIT.
// 4. Default MIN_BYTES=64, frame 1 -> kill=1 (runt) although crc_q=C704DD7B.
//    Frame 1 minus its final dibit -> kill=1 (51 beats, 102 bits, not byte aligned).
// 5. rst pulled low for 1 cycle at beat 20 of frame 1 -> outputs 0 immediately, no done.
//    The next clean frame 1 -> kill=0.
// 6. DW=8: frame 1 as 13 byte beats -> done 1 cycle after beat 13, kill=0, crc_q=C704DD7B.
//    DW=1 variant: 104 beats -> same result.

Source files
------------

// File: rtl/crc32_frame_check.sv
// Streaming CRC-32 frame checker: folds DW wire-order bits per beat and
// reports a pass/kill verdict one cycle after each frame ends.
module crc32_frame_check #(
  parameter int          DW        = 2,
  parameter logic [31:0] POLY      = 32'h04C11DB7,
  parameter logic [31:0] INIT      = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE   = 32'hC704DD7B,
  parameter int          MIN_BYTES = 64,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             axiiv,
  input  logic [DW-1:0]    axiid,
  output logic             done,
  output logic             kill,
  output logic [31:0]      crc_q,
  output logic [CNT_W-1:0] byte_count
);

  localparam int BW = CNT_W + 3;
  localparam logic [CNT_W-1:0] MINB = CNT_W'(MIN_BYTES);
  localparam logic [BW-1:0]    BMAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    REPORT
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      crc_r_q, crc_r_d;
  logic [BW-1:0]    bits_q, bits_d;
  logic [31:0]      crc_h_q, crc_h_d;
  logic [CNT_W-1:0] bc_q, bc_d;
  logic             done_q, done_d;
  logic             kill_q, kill_d;

  logic [BW:0]      bits_sum;
  logic [BW-1:0]    bits_sat;
  logic             verdict;

  // Unrolled serial LFSR: bit 0 of the beat is the earliest on the wire.
  function automatic logic [31:0] fold(
    input logic [31:0]   c,
    input logic [DW-1:0] d
  );
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < DW; i++) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    return r;
  endfunction

  assign bits_sum = {1'b0, bits_q} + (BW+1)'(DW);
  assign bits_sat = bits_sum[BW] ? BMAX : bits_sum[BW-1:0];

  assign verdict = (crc_r_q != RESIDUE)
                 | (bits_q[BW-1:3] < MINB)
                 | (bits_q[2:0] != 3'd0);

  always_comb begin
    state_d = state_q;
    crc_r_d = crc_r_q;
    bits_d  = bits_q;
    crc_h_d = crc_h_q;
    bc_d    = bc_q;
    done_d  = 1'b0;
    kill_d  = 1'b0;
    unique case (state_q)
      IDLE, REPORT: begin
        if (axiiv) begin
          state_d = RUN;
          crc_r_d = fold(INIT, axiid);
          bits_d  = BW'(DW);
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (axiiv) begin
          crc_r_d = fold(crc_r_q, axiid);
          bits_d  = bits_sat;
        end else begin
          state_d = REPORT;
          crc_h_d = crc_r_q;
          bc_d    = bits_q[BW-1:3];
          done_d  = 1'b1;
          kill_d  = verdict;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      crc_r_q <= INIT;
      bits_q  <= '0;
      crc_h_q <= '0;
      bc_q    <= '0;
      done_q  <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_r_q <= crc_r_d;
      bits_q  <= bits_d;
      crc_h_q <= crc_h_d;
      bc_q    <= bc_d;
      done_q  <= done_d;
      kill_q  <= kill_d;
    end
  end

  assign done       = done_q;
  assign kill       = kill_q;
  assign crc_q      = crc_h_q;
  assign byte_count = bc_q;

endmodule

// File: tb/tb_crc32_frame_check.sv
// Scoreboard bench for crc32_frame_check across DW=1/2/8 and two
// MIN_BYTES settings using the "123456789" + FCS reference frame.
module tb_crc32_frame_check;

  localparam logic [31:0] RES = 32'hC704DD7B;

  typedef struct {
    logic        kill;
    logic [31:0] crc;
    int          mode;
    logic [15:0] bc;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       va, vb, vc, vd;
  logic [1:0] da, db;
  logic [7:0] dc;
  logic [0:0] dd;

  logic        done_a, done_b, done_c, done_d;
  logic        kill_a, kill_b, kill_c, kill_d;
  logic [31:0] crc_a, crc_b, crc_c, crc_d;
  logic [15:0] bc_a, bc_b, bc_c, bc_d;

  crc32_frame_check #(.DW(2), .MIN_BYTES(4)) u_a (
    .clk(clk), .rst(rst), .axiiv(va), .axiid(da),
    .done(done_a), .kill(kill_a), .crc_q(crc_a), .byte_count(bc_a)
  );
  crc32_frame_check #(.DW(2)) u_b (
    .clk(clk), .rst(rst), .axiiv(vb), .axiid(db),
    .done(done_b), .kill(kill_b), .crc_q(crc_b), .byte_count(bc_b)
  );
  crc32_frame_check #(.DW(8), .MIN_BYTES(4)) u_c (
    .clk(clk), .rst(rst), .axiiv(vc), .axiid(dc),
    .done(done_c), .kill(kill_c), .crc_q(crc_c), .byte_count(bc_c)
  );
  crc32_frame_check #(.DW(1), .MIN_BYTES(4)) u_d (
    .clk(clk), .rst(rst), .axiiv(vd), .axiid(dd),
    .done(done_d), .kill(kill_d), .crc_q(crc_d), .byte_count(bc_d)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t qd[$];

  logic [103:0] f1, f2;

  task automatic cmp(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  task automatic chk(input int inst, input logic dn, input logic kl,
                     input logic [31:0] c, input logic [15:0] bc);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (!dn) begin
      cmp($sformatf("kill_idle_%0d", inst), {31'd0, kl}, 32'd0);
      return;
    end
    case (inst)
      0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
      1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
      2: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
      default:
         if (qd.size() > 0) begin e = qd.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      total++;
      bad++;
      $display("FAIL unexpected_done_%0d got=1 want=0 cyc=%0d", inst, cyc);
      return;
    end
    cmp($sformatf("done_cyc_%0d", inst), 32'(cyc), 32'(e.cyc));
    cmp($sformatf("kill_%0d", inst), {31'd0, kl}, {31'd0, e.kill});
    cmp($sformatf("bytes_%0d", inst), {16'd0, bc}, {16'd0, e.bc});
    if (e.mode == 0) begin
      cmp($sformatf("crc_%0d", inst), c, e.crc);
    end else if (e.mode == 1) begin
      total++;
      if (c == e.crc) begin
        bad++;
        $display("FAIL crc_ne_%0d got=%h want!=%h", inst, c, e.crc);
      end
    end
  endtask

  always @(negedge clk) begin
    chk(0, done_a, kill_a, crc_a, bc_a);
    chk(1, done_b, kill_b, crc_b, bc_b);
    chk(2, done_c, kill_c, crc_c, bc_c);
    chk(3, done_d, kill_d, crc_d, bc_d);
  end

  // Called at a negedge; returns at the negedge where done is visible.
  task automatic send(input int inst, input logic [103:0] s,
                      input int nbits, input logic ek, input int mode,
                      input logic [15:0] ebc);
    exp_t e;
    int   dw;
    dw = (inst == 2) ? 8 : (inst == 3) ? 1 : 2;
    for (int b = 0; b < nbits; b += dw) begin
      case (inst)
        0: begin va = 1'b1; da = s[b +: 2]; end
        1: begin vb = 1'b1; db = s[b +: 2]; end
        2: begin vc = 1'b1; dc = s[b +: 8]; end
        default: begin vd = 1'b1; dd = s[b +: 1]; end
      endcase
      @(negedge clk);
    end
    case (inst)
      0: begin va = 1'b0; da = 'x; end
      1: begin vb = 1'b0; db = 'x; end
      2: begin vc = 1'b0; dc = 'x; end
      default: begin vd = 1'b0; dd = 'x; end
    endcase
    e.kill = ek;
    e.crc  = RES;
    e.mode = mode;
    e.bc   = ebc;
    e.cyc  = cyc + 1;
    case (inst)
      0: qa.push_back(e);
      1: qb.push_back(e);
      2: qc.push_back(e);
      default: qd.push_back(e);
    endcase
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    f1 = {8'hCB, 8'hF4, 8'h39, 8'h26,
          8'h39, 8'h38, 8'h37, 8'h36, 8'h35,
          8'h34, 8'h33, 8'h32, 8'h31};
    f2 = f1 ^ (104'd1 << 10);
    va = 1'b0; vb = 1'b0; vc = 1'b0; vd = 1'b0;
    da = 'x; db = 'x; dc = 'x; dd = 'x;
    idle(2);
    cmp("rst_done", {31'd0, done_a}, 32'd0);
    cmp("rst_kill", {31'd0, kill_a}, 32'd0);
    cmp("rst_crc", crc_a, 32'd0);
    cmp("rst_bytes", {16'd0, bc_a}, 32'd0);
    cmp("rst_crc_c", crc_c, 32'd0);
    rst = 1'b1;
    idle(2);

    send(0, f1, 104, 1'b0, 0, 16'd13);
    idle(3);
    send(0, f2, 104, 1'b1, 1, 16'd13);
    idle(3);
    send(0, f1, 104, 1'b0, 0, 16'd13);
    send(0, f2, 104, 1'b1, 1, 16'd13);
    send(0, f1, 104, 1'b0, 0, 16'd13);
    idle(3);

    send(1, f1, 104, 1'b1, 0, 16'd13);
    send(0, f1, 102, 1'b1, 2, 16'd12);
    idle(3);

    for (int b = 0; b < 40; b += 2) begin
      va = 1'b1;
      da = f1[b +: 2];
      @(negedge clk);
    end
    rst = 1'b0;
    va  = 1'b0;
    da  = 'x;
    #1;
    cmp("midrst_done", {31'd0, done_a}, 32'd0);
    cmp("midrst_kill", {31'd0, kill_a}, 32'd0);
    cmp("midrst_crc", crc_a, 32'd0);
    cmp("midrst_bytes", {16'd0, bc_a}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(5);
    send(0, f1, 104, 1'b0, 0, 16'd13);
    idle(3);

    send(2, f1, 104, 1'b0, 0, 16'd13);
    idle(2);
    send(3, f1, 104, 1'b0, 0, 16'd13);
    idle(10);

    cmp("pending_a", 32'(qa.size()), 32'd0);
    cmp("pending_b", 32'(qb.size()), 32'd0);
    cmp("pending_c", 32'(qc.size()), 32'd0);
    cmp("pending_d", 32'(qd.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
